uart_rx: RTL and testbench

- Synthesizable 8N1 UART receiver, the receive end of the SoC serial link.
- Deserialises the SoC `UART_txd` stream, or an external host's line, using 16x oversampling.
- Buffers received bytes in a small FWFT FIFO behind a valid/ready handshake.
- Reports framing errors and FIFO overrun to the owning peripheral or bench monitor.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame/oversampling constants.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_SAMPLE = 8;
   localparam int unsigned DATA_BITS  = 8;

   // Bit counter width, shared with the transmitter
   localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);
   localparam int unsigned TICK_CNT_W = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO. The head entry is always visible on
// pop_data. A pop is applied before a push, so a full FIFO accepts a push that
// coincides with a pop.
module uart_rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   // Qualify requests: pop on empty is ignored, push on full only if a pop frees a slot
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == FULL_CNT);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      pop_data = mem_q[rd_ptr_q];
   end

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, framing-error detection and an FWFT
// receive FIFO with sticky overrun flag.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   input  logic [DIV_W-1:0]     baud_div,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 clr_err,
   output logic                 busy
);

   localparam logic [TICK_CNT_W-1:0] MID_LAST = TICK_CNT_W'(MID_SAMPLE - 1);
   localparam logic [TICK_CNT_W-1:0] OS_LAST  = TICK_CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_CNT_W-1:0]  BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

   logic                  sync1_q;
   logic                  rxs;
   rx_state_t             state_q;
   logic [DIV_W-1:0]      div_q;
   logic [DIV_W-1:0]      div_cnt_q;
   logic [TICK_CNT_W-1:0] tick_cnt_q;
   logic [BIT_CNT_W-1:0]  bit_cnt_q;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  frame_err_q;
   logic                  busy_q;
   logic                  overrun_q;
   logic                  tick;
   logic                  push;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;

   // Two-flop synchroniser, idle-high reset so no false start leaves reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rxs     <= sync1_q;
      end
   end

   // Oversample tick strobe and good-stop push decode
   always_comb begin
      tick = (state_q != IDLE) && (div_cnt_q == div_q);
      push = (state_q == STOP) && tick && (tick_cnt_q == OS_LAST) && rxs;
      pop  = rx_valid && rx_ready;
   end

   // Tick divider: held at zero while idle so each frame starts phase-aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else if (state_q == IDLE || tick) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_q + 1'b1;
      end
   end

   // Receive FSM with registered busy and frame_err outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         div_q       <= '0;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxs) begin
                  div_q      <= baud_div;
                  tick_cnt_q <= '0;
                  state_q    <= START;
                  busy_q     <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (tick_cnt_q == MID_LAST) begin
                     if (!rxs) begin
                        state_q    <= DATA;
                        bit_cnt_q  <= '0;
                        tick_cnt_q <= '0;
                     end else begin
                        // Glitch shorter than half a bit: not a real start bit
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  // Tick count wraps 15 -> 0, giving one sample per bit period
                  tick_cnt_q <= tick_cnt_q + 1'b1;
                  if (tick_cnt_q == OS_LAST) begin
                     shift_q   <= {rxs, shift_q[DATA_BITS-1:1]};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == BIT_LAST) begin
                        state_q <= STOP;
                     end
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
                  if (tick_cnt_q == OS_LAST) begin
                     if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                     end
                  end
               end
            end
            BREAK: begin
               // Line stuck low: wait for it to recover before hunting again
               if (rxs) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun: a byte lost to a full FIFO; set has priority over clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         overrun_q <= 1'b1;
      end else if (clr_err) begin
         overrun_q <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (shift_q),
      .pop       (pop),
      .pop_data  (rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Output mapping
   always_comb begin
      rx_valid  = !fifo_empty;
      frame_err = frame_err_q;
      overrun   = overrun_q;
      busy      = busy_q;
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected bytes, a monitor pops
// and compares them on every rx_valid & rx_ready handshake.
module tb_uart_rx;

   logic        clk;
   logic        rst_n;
   logic        rxd;
   logic [15:0] baud_div;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        frame_err;
   logic        overrun;
   logic        clr_err;
   logic        busy;

   int          vectors;
   int          miscompares;
   int          fe_cnt;
   int          valid_cycles;
   int          bit_clks;
   logic [7:0]  exp_q [$];

   uart_rx #(
      .FIFO_DEPTH (4),
      .DIV_W      (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (rxd),
      .baud_div  (baud_div),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .clr_err   (clr_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one 8N1 frame starting at a negedge; bit_clks clocks per bit
   task automatic send(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (bit_clks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (bit_clks) @(negedge clk);
      end
      rxd = stop;
      repeat (bit_clks) @(negedge clk);
   endtask

   // Monitor: compare every handshake against the scoreboard, count pulses
   initial begin
      logic [7:0] req;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (frame_err) fe_cnt++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_pop: got 0x%0h, required no byte at %0t",
                           rx_data, $time);
               end else begin
                  req = exp_q.pop_front();
                  check("rx_data_pop", {24'd0, rx_data}, {24'd0, req});
               end
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vectors      = 0;
      miscompares  = 0;
      fe_cnt       = 0;
      valid_cycles = 0;
      bit_clks     = 64;
      rst_n        = 1'b0;
      rxd          = 1'b1;
      baud_div     = 16'd3;
      rx_ready     = 1'b0;
      clr_err      = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Basic byte
      rx_ready = 1'b1;
      exp_q.push_back(8'hA5);
      fork
         send(8'hA5, 1'b1);
         begin
            repeat (100) @(negedge clk);
            check("basic_busy_mid", busy, 1);
         end
      join
      repeat (10) @(negedge clk);
      check("basic_delivered", exp_q.size(), 0);
      check("basic_valid_1cyc", valid_cycles, 1);
      check("basic_frame_err", fe_cnt, 0);
      check("basic_overrun", overrun, 0);
      check("basic_busy_end", busy, 0);

      // False start
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      check("false_busy_start", busy, 1);
      repeat (40) @(negedge clk);
      check("false_busy_idle", busy, 0);
      check("false_no_valid", valid_cycles, 1);

      // Framing error with line held low
      send(8'h3C, 1'b0);
      repeat (200) @(negedge clk);
      check("ferr_pulse_1cyc", fe_cnt, 1);
      check("ferr_busy_break", busy, 1);
      check("ferr_fifo_empty", rx_valid, 0);
      rxd = 1'b1;
      repeat (5) @(negedge clk);
      check("ferr_busy_idle", busy, 0);
      check("ferr_no_repeat", fe_cnt, 1);
      repeat (20) @(negedge clk);

      // Overrun: five bytes into a four-entry FIFO
      rx_ready = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         if (b <= 4) exp_q.push_back(8'(b));
         send(8'(b), 1'b1);
         repeat (4) @(negedge clk);
      end
      check("ovr_set", overrun, 1);
      check("ovr_head", rx_data, 8'h01);
      rx_ready = 1'b1;
      repeat (8) @(negedge clk);
      rx_ready = 1'b0;
      check("ovr_drained", exp_q.size(), 0);
      check("ovr_empty", rx_valid, 0);
      check("ovr_sticky", overrun, 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("ovr_cleared", overrun, 0);

      // Pop coinciding with push into a full FIFO
      for (int b = 1; b <= 4; b++) begin
         exp_q.push_back(8'(b));
         send(8'(b), 1'b1);
         repeat (4) @(negedge clk);
      end
      check("full_no_ovr", overrun, 0);
      exp_q.push_back(8'h55);
      fork
         send(8'h55, 1'b1);
         begin
            // Stop sample lands in the cycle after the 610th posedge
            repeat (610) @(posedge clk);
            @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
         end
      join
      check("simul_no_ovr", overrun, 0);
      check("simul_head", rx_data, 8'h02);
      rx_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("simul_drained", exp_q.size(), 0);
      check("simul_empty", rx_valid, 0);

      // Reset during data bit 4 with a byte parked in the FIFO
      rx_ready = 1'b0;
      exp_q.push_back(8'h99);
      send(8'h99, 1'b1);
      repeat (4) @(negedge clk);
      check("pre_rst_head", rx_data, 8'h99);
      rxd = 1'b0;
      repeat (bit_clks) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = i[0];
         repeat (bit_clks) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (bit_clks / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_rx_data", rx_data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_overrun", overrun, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      rx_ready = 1'b1;
      exp_q.push_back(8'h7E);
      send(8'h7E, 1'b1);
      repeat (10) @(negedge clk);
      check("post_rst_delivered", exp_q.size(), 0);

      // baud_div=0 (16 clocks/bit); a mid-frame divisor change must not disturb it
      baud_div = 16'd0;
      bit_clks = 16;
      exp_q.push_back(8'h96);
      send(8'h96, 1'b1);
      repeat (10) @(negedge clk);
      check("div0_delivered", exp_q.size(), 0);
      exp_q.push_back(8'h5A);
      fork
         send(8'h5A, 1'b1);
         begin
            repeat (40) @(negedge clk);
            baud_div = 16'd3;
         end
      join
      repeat (10) @(negedge clk);
      check("divchg_delivered", exp_q.size(), 0);
      check("final_frame_err", fe_cnt, 1);
      check("final_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
